local_history_table: RTL and testbench
======================================

LOCAL_HISTORY_TABLE -- requirements
Module: local_history_table

Interface
REQ-001 Parameter ENTRIES, default 64, number of per-branch history registers (power of two, 2..1024).
REQ-002 Parameter HIST_W, default 10, history length in bits; equals the pattern-table index width of the local predictor.
REQ-003 Parameter PC_W, default 32, program-counter width.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 lookup_valid  input  1  lookup request for lookup_pc this cycle.
REQ-007 lookup_pc  input  PC_W  PC of the branch being fetched.
REQ-008 lookup_ready  output  1  table accepts lookups; a lookup is accepted when lookup_valid && lookup_ready.
REQ-009 hist_valid  output  1  hist_out holds the result of a lookup accepted the previous cycle.
REQ-010 hist_out  output  HIST_W  local history for the looked-up branch; drives the predictor's historyTable input.
REQ-011 update_valid  input  1  resolved-branch update this cycle.
REQ-012 update_pc  input  PC_W  PC of the resolved branch.
REQ-013 update_taken  input  1  resolved outcome, 1 = taken.
REQ-014 update_ready  output  1  table accepts updates; an update is accepted when update_valid && update_ready.

Function
REQ-015 Entry index SHALL be pc[log2(ENTRIES)+1:2]; higher PC bits are ignored, so aliasing PCs share an entry.
REQ-016 The FSM SHALL have two states: INIT and RUN.
REQ-017 INIT SHALL clear one entry per cycle to all-zero, from index 0 to ENTRIES-1, using an init counter.
REQ-018 INIT SHALL transition to RUN on the cycle after index ENTRIES-1 is cleared, after exactly ENTRIES cycles.
REQ-019 In INIT, lookup_ready and update_ready SHALL be 0, and requests SHALL be ignored with no state change.
REQ-020 In RUN, lookup_ready and update_ready SHALL be 1.
REQ-021 An accepted update SHALL write entry <= {entry[HIST_W-2:0], update_taken}: shift left, newest outcome in bit 0, oldest bit discarded, no saturation.
REQ-022 An accepted lookup SHALL register the entry into hist_out and assert hist_valid on the next rising edge; latency is 1 cycle.
REQ-023 hist_valid SHALL be 0 in any cycle not preceded by an accepted lookup.
REQ-024 hist_out SHALL hold its last value when hist_valid is 0.
REQ-025 Same-cycle lookup and update to the same index SHALL return the post-update history (write-first bypass).
REQ-026 Same-cycle lookup and update to different indices SHALL both complete with no interference.
REQ-027 Back-to-back lookups SHALL be accepted every cycle, giving one result per cycle.
REQ-028 Back-to-back updates to one index SHALL accumulate, each shift seeing the previous update.

Reset
REQ-029 While reset is low: FSM = INIT, init counter = 0, hist_valid = 0, hist_out = 0, lookup_ready = 0, update_ready = 0.
REQ-030 Entry contents need not be reset asynchronously; they SHALL be zeroed by the INIT sweep before RUN.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL abort the current activity, discard any in-flight lookup result, and restart the full INIT sweep from index 0 after deassertion.

Verification
REQ-032 Release reset, hold lookup_valid=1 -> lookup_ready=0 for exactly 64 cycles, then 1; the first accepted lookup returns hist_out=0 with hist_valid one cycle later.
REQ-033 Updates on pc=0x40 with taken 1,1,0 on consecutive cycles, then lookup pc=0x40 -> hist_out=10'b0000000110.
REQ-034 Eleven consecutive taken updates on pc=0x80, then lookup -> hist_out=10'h3FF; one further not-taken update -> 10'h3FE.
REQ-035 Entry for pc=0x10 holds 0; same cycle lookup pc=0x10 and update pc=0x10 taken=1 -> next cycle hist_out=10'h001 (bypass).
REQ-036 Update pc=0x004 taken=1, then lookup pc=0x104 (same index when ENTRIES=64) -> hist_out=10'h001 (alias); lookup pc=0x008 -> 10'h000.
REQ-037 Assert reset 20 cycles into INIT, release -> lookup_ready stays 0 for a full 64 cycles from release; hist_valid=0 throughout.

Source files
------------

// File: rtl/local_history_table_if.sv
// Lookup/update port bundle of the local history table: fetch-side lookups
// and resolve-side history updates.
interface local_history_table_if #(
  parameter int PC_W   = 32,
  parameter int HIST_W = 10
);
  logic              lookup_valid;
  logic              lookup_ready;
  logic [PC_W-1:0]   lookup_pc;
  logic              hist_valid;
  logic [HIST_W-1:0] hist_out;
  logic              update_valid;
  logic              update_ready;
  logic [PC_W-1:0]   update_pc;
  logic              update_taken;

  modport master (
    output lookup_valid, lookup_pc, update_valid, update_pc, update_taken,
    input  lookup_ready, hist_valid, hist_out, update_ready
  );

  modport slave (
    input  lookup_valid, lookup_pc, update_valid, update_pc, update_taken,
    output lookup_ready, hist_valid, hist_out, update_ready
  );
endinterface

// File: rtl/local_history_table.sv
// Per-branch local history shift registers indexed by PC. After reset an INIT
// sweep zeroes every entry before lookups and updates are accepted.
module local_history_table #(
  parameter int ENTRIES = 64,
  parameter int HIST_W  = 10,
  parameter int PC_W    = 32
) (
  input logic              clk,
  input logic              rst_n,
  local_history_table_if.slave bus
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
  logic              hist_valid_q, hist_valid_d;
  logic [HIST_W-1:0] hist_out_q, hist_out_d;
  logic [HIST_W-1:0] mem_q [ENTRIES];

  logic [PC_W-1:0]   lk_pc, up_pc;
  logic [IDX_W-1:0]  lk_idx, up_idx, wr_idx;
  logic              run, lk_fire, up_fire, wr_en;
  logic [HIST_W-1:0] up_hist, wr_data;

  assign run     = (state_q == RUN);
  assign lk_pc   = bus.lookup_pc;
  assign up_pc   = bus.update_pc;
  // Byte offset bits are dropped; bits above the index alias onto one entry.
  assign lk_idx  = IDX_W'(lk_pc >> 2);
  assign up_idx  = IDX_W'(up_pc >> 2);
  assign lk_fire = bus.lookup_valid && run;
  assign up_fire = bus.update_valid && run;
  assign up_hist = {mem_q[up_idx][HIST_W-2:0], bus.update_taken};

  assign bus.lookup_ready = run;
  assign bus.update_ready = run;
  assign bus.hist_valid   = hist_valid_q;
  assign bus.hist_out     = hist_out_q;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    hist_valid_d = lk_fire;
    hist_out_d   = hist_out_q;
    wr_en        = 1'b0;
    wr_idx       = up_idx;
    wr_data      = up_hist;
    case (state_q)
      INIT: begin
        wr_en      = 1'b1;
        wr_idx     = init_cnt_q;
        wr_data    = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == IDX_W'(ENTRIES - 1)) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end
      end
      RUN: begin
        wr_en = up_fire;
        // Write-first: a same-index update this cycle is visible to the lookup.
        if (lk_fire) begin
          hist_out_d = (up_fire && (up_idx == lk_idx)) ? up_hist : mem_q[lk_idx];
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      init_cnt_q   <= '0;
      hist_valid_q <= 1'b0;
      hist_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      hist_valid_q <= hist_valid_d;
      hist_out_q   <= hist_out_d;
    end
  end

  // Storage has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end
endmodule

// File: tb/tb_local_history_table.sv
// Randomized and directed bench for local_history_table with a queue-based
// scoreboard fed by a per-entry history model.
module tb_local_history_table;
  localparam int ENTRIES = 64;
  localparam int HIST_W  = 10;
  localparam int PC_W    = 32;

  typedef struct {
    int               cyc;
    logic [HIST_W-1:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   since  = 0;
  int   model [ENTRIES];
  exp_t q [$];

  local_history_table_if #(.PC_W(PC_W), .HIST_W(HIST_W)) bus ();

  local_history_table #(.ENTRIES(ENTRIES), .HIST_W(HIST_W), .PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int idx_of(input logic [PC_W-1:0] pc);
    return int'(pc >> 2) % ENTRIES;
  endfunction

  function automatic int next_hist(input int h, input logic t);
    return ((h * 2) + int'(t)) % (1 << HIST_W);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < ENTRIES; i++) model[i] = 0;
  endtask

  // One cycle of stimulus; cval >= 0 forces a known expected lookup result.
  task automatic step(input logic lv, input logic [PC_W-1:0] lpc,
                      input logic uv, input logic [PC_W-1:0] upc,
                      input logic ut, input int cval);
    bit rdy_exp;
    int li, ui, e;
    rdy_exp = (since >= ENTRIES);
    n_chk++;
    if (bus.lookup_ready !== rdy_exp || bus.update_ready !== rdy_exp) begin
      n_fail++;
      $display("FAIL ready: since=%0d lookup_ready=%b update_ready=%b required=%b",
               since, bus.lookup_ready, bus.update_ready, rdy_exp);
    end
    bus.lookup_valid = lv;
    bus.lookup_pc    = lpc;
    bus.update_valid = uv;
    bus.update_pc    = upc;
    bus.update_taken = ut;
    li = idx_of(lpc);
    ui = idx_of(upc);
    if (rdy_exp && lv) begin
      e = (uv && ui == li) ? next_hist(model[ui], ut) : model[li];
      if (cval >= 0) e = cval;
      q.push_back('{cyc + 1, HIST_W'(e)});
    end
    if (rdy_exp && uv) model[ui] = next_hist(model[ui], ut);
    @(posedge clk);
    #1;
    since++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, -1);
  endtask

  // Asserts reset mid-cycle, dropping anything in flight, then releases.
  task automatic do_reset(input int n);
    #2;
    rst_n = 1'b0;
    q.delete();
    bus.lookup_valid = 1'b0;
    bus.update_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    since = 0;
    clear_model();
  endtask

  task automatic init_phase(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, $urandom, 1'b1, $urandom, 1'($urandom_range(0, 1)), -1);
  endtask

  function automatic logic [PC_W-1:0] rand_pc();
    logic [PC_W-1:0] p;
    p = $urandom;
    if ($urandom_range(0, 1) == 1) p = (p & ~32'h0000_00FC) | (32'($urandom_range(0, 7)) << 2);
    return p;
  endfunction

  initial begin : monitor
    logic [HIST_W-1:0] last_out;
    last_out = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_out = '0;
        n_chk++;
        if (bus.hist_valid !== 1'b0 || bus.hist_out !== '0) begin
          n_fail++;
          $display("FAIL reset_out: hist_valid=%b hist_out=%h required 0/000",
                   bus.hist_valid, bus.hist_out);
        end
      end else if (q.size() > 0 && q[0].cyc == cyc) begin
        n_chk++;
        if (bus.hist_valid !== 1'b1 || bus.hist_out !== q[0].val) begin
          n_fail++;
          $display("FAIL lookup: cyc=%0d hist_valid=%b hist_out=%h required 1/%h",
                   cyc, bus.hist_valid, bus.hist_out, q[0].val);
        end
        last_out = q[0].val;
        void'(q.pop_front());
      end else begin
        n_chk++;
        if (bus.hist_valid !== 1'b0 || bus.hist_out !== last_out) begin
          n_fail++;
          $display("FAIL idle_out: cyc=%0d hist_valid=%b hist_out=%h required 0/%h",
                   cyc, bus.hist_valid, bus.hist_out, last_out);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    bus.lookup_valid = 1'b0;
    bus.lookup_pc    = '0;
    bus.update_valid = 1'b0;
    bus.update_pc    = '0;
    bus.update_taken = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    since = 0;

    // INIT with requests held: all ignored, first accepted lookup reads zero
    init_phase(ENTRIES);
    step(1'b1, $urandom, 1'b0, '0, 1'b0, 0);

    // Accumulating updates on one entry
    step(1'b0, '0, 1'b1, 32'h40, 1'b1, -1);
    step(1'b0, '0, 1'b1, 32'h40, 1'b1, -1);
    step(1'b0, '0, 1'b1, 32'h40, 1'b0, -1);
    step(1'b1, 32'h40, 1'b0, '0, 1'b0, 10'b0000000110);

    // Shift without saturation
    for (int i = 0; i < 11; i++) step(1'b0, '0, 1'b1, 32'h80, 1'b1, -1);
    step(1'b1, 32'h80, 1'b0, '0, 1'b0, 10'h3FF);
    step(1'b0, '0, 1'b1, 32'h80, 1'b0, -1);
    step(1'b1, 32'h80, 1'b0, '0, 1'b0, 10'h3FE);

    // Write-first bypass, aliasing, and independent same-cycle traffic
    step(1'b1, 32'h10, 1'b1, 32'h10, 1'b1, 10'h001);
    step(1'b0, '0, 1'b1, 32'h004, 1'b1, -1);
    step(1'b1, 32'h104, 1'b0, '0, 1'b0, 10'h001);
    step(1'b1, 32'h008, 1'b0, '0, 1'b0, 10'h000);
    step(1'b1, 32'h80, 1'b1, 32'h40, 1'b1, 10'h3FE);
    step(1'b1, 32'h40, 1'b0, '0, 1'b0, 10'h00D);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h40 + 32'(i * 4), 1'b0, '0, 1'b0, -1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)), rand_pc(),
           1'($urandom_range(0, 1)), -1);

    // Reset mid-RUN with a lookup in flight; sweep must clear old histories
    step(1'b1, 32'h80, 1'b0, '0, 1'b0, -1);
    do_reset(2);
    init_phase(ENTRIES);
    step(1'b1, 32'h40, 1'b0, '0, 1'b0, 0);
    step(1'b1, 32'h80, 1'b0, '0, 1'b0, 0);
    step(1'b1, 32'h004, 1'b0, '0, 1'b0, 0);

    // Reset 20 cycles into INIT restarts the full sweep
    do_reset(2);
    init_phase(20);
    do_reset(3);
    init_phase(ENTRIES);
    step(1'b1, 32'h10, 1'b1, 32'h10, 1'b0, 0);
    step(1'b1, 32'h10, 1'b0, '0, 1'b0, 0);
    for (int i = 0; i < 30; i++)
      step(1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)), rand_pc(),
           1'($urandom_range(0, 1)), -1);
    idle(3);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d lookup results outstanding, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
